mem_stage_sramlike: RTL

- Next-generation MEM pipeline stage for the 5-stage LoongArch core, placed between EX and WB.
- Targets an SRAM-like split-transaction data bus (req/addr_ok, then data_ok/rdata), so the stage stalls until the response for its instruction returns.
- Buffers early responses and tracks outstanding requests. After a flush it drops the responses that belong to cancelled instructions.
- Performs load byte/half selection and sign/zero extension. Exports forwarding and stall info to ID.

---
 rtl/mem_stage_sramlike.sv | 168 ++++++++++++++++
 1 files changed

// File: rtl/mem_stage_sramlike.sv
// MEM stage for an SRAM-like split-transaction data bus: waits for its own response,
// buffers it if WB stalls, and drops responses that belong to flushed instructions.
module mem_stage_sramlike #(
  parameter int MAX_OUTSTANDING = 2,
  parameter int SIDE_W          = 128
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              ex_mem_valid,
  output logic              mem_allowin,
  input  logic              ex_has_req,
  input  logic              ex_gr_we,
  input  logic              ex_res_from_mem,
  input  logic [2:0]        ex_mem_type,
  input  logic [1:0]        ex_addr_low2,
  input  logic [4:0]        ex_dest,
  input  logic [31:0]       ex_pc,
  input  logic [31:0]       ex_alu_result,
  input  logic              ex_exc,
  input  logic [SIDE_W-1:0] ex_side,
  input  logic              data_sram_req,
  input  logic              data_sram_addr_ok,
  input  logic              data_sram_data_ok,
  input  logic [31:0]       data_sram_rdata,
  output logic              req_block,
  output logic              mem_wb_valid,
  input  logic              wb_allowin,
  output logic              wb_gr_we,
  output logic [4:0]        wb_dest,
  output logic [31:0]       wb_pc,
  output logic [31:0]       wb_result,
  output logic              wb_exc,
  output logic [SIDE_W-1:0] wb_side,
  output logic              mem_exc,
  input  logic              flush,
  output logic              fwd_valid,
  output logic [4:0]        fwd_dest,
  output logic [31:0]       fwd_data,
  output logic              fwd_busy
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic              vld_p1, need_resp_p1, rbuf_valid;
  logic              gr_we_p1, res_from_mem_p1, exc_p1;
  logic [2:0]        mem_type_p1;
  logic [1:0]        low2_p1;
  logic [4:0]        dest_p1;
  logic [31:0]       pc_p1, alu_p1, rbuf;
  logic [SIDE_W-1:0] side_p1;
  logic [CNT_W-1:0]  out_cnt, out_cnt_nxt, discard_cnt;
  logic              req_hs, resp_ok, ready_go, latch, rbuf_cap;
  logic [31:0]       load_raw, result;

  function automatic logic [31:0] load_extend(input logic [31:0] raw,
                                              input logic [1:0]  low2,
                                              input logic [2:0]  mtype);
    logic signed [15:0] half_s;
    logic signed [7:0]  byte_s;
    logic signed [31:0] ext_s;
    half_s = low2[1] ? raw[31:16] : raw[15:0];
    case (low2)
      2'd0:    byte_s = raw[7:0];
      2'd1:    byte_s = raw[15:8];
      2'd2:    byte_s = raw[23:16];
      default: byte_s = raw[31:24];
    endcase
    case (mtype[1:0])
      2'b01: begin
        ext_s = half_s;
        load_extend = mtype[2] ? {16'h0, half_s} : ext_s;
      end
      2'b10: begin
        ext_s = byte_s;
        load_extend = mtype[2] ? {24'h0, byte_s} : ext_s;
      end
      default: load_extend = raw;
    endcase
  endfunction

  assign req_hs      = data_sram_req & data_sram_addr_ok;
  assign out_cnt_nxt = out_cnt + CNT_W'(req_hs) - CNT_W'(data_sram_data_ok);
  assign resp_ok     = data_sram_data_ok & (discard_cnt == '0);
  assign ready_go    = ~need_resp_p1 | rbuf_valid | resp_ok;
  assign mem_allowin = ~vld_p1 | (ready_go & wb_allowin);
  assign latch       = ex_mem_valid & mem_allowin & ~flush;
  assign rbuf_cap    = resp_ok & vld_p1 & need_resp_p1 & ~rbuf_valid & ~wb_allowin;
  assign load_raw    = rbuf_valid ? rbuf : data_sram_rdata;
  assign result      = res_from_mem_p1 ? load_extend(load_raw, low2_p1, mem_type_p1) : alu_p1;

  // Outstanding-request tracking; on flush every in-flight response is stale.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      out_cnt     <= '0;
      discard_cnt <= '0;
    end else begin
      out_cnt <= out_cnt_nxt;
      if (flush)
        discard_cnt <= out_cnt_nxt;
      else if (data_sram_data_ok && discard_cnt != '0)
        discard_cnt <= discard_cnt - CNT_W'(1);
    end
  end

  // EX -> MEM stage boundary (control)
  always_ff @(posedge clk) begin
    if (!resetn) begin
      vld_p1       <= 1'b0;
      need_resp_p1 <= 1'b0;
      rbuf_valid   <= 1'b0;
    end else if (flush) begin
      vld_p1     <= 1'b0;
      rbuf_valid <= 1'b0;
    end else begin
      if (mem_allowin) begin
        vld_p1     <= ex_mem_valid;
        rbuf_valid <= 1'b0;
      end else if (rbuf_cap) begin
        rbuf_valid <= 1'b1;
      end
      if (latch) need_resp_p1 <= ex_has_req;
    end
  end

  // EX -> MEM stage boundary (payload); cleared on reset so idle outputs read zero
  always_ff @(posedge clk) begin
    if (!resetn) begin
      gr_we_p1        <= 1'b0;
      res_from_mem_p1 <= 1'b0;
      exc_p1          <= 1'b0;
      mem_type_p1     <= '0;
      low2_p1         <= '0;
      dest_p1         <= '0;
      pc_p1           <= '0;
      alu_p1          <= '0;
      side_p1         <= '0;
    end else if (latch) begin
      gr_we_p1        <= ex_gr_we;
      res_from_mem_p1 <= ex_res_from_mem;
      exc_p1          <= ex_exc;
      mem_type_p1     <= ex_mem_type;
      low2_p1         <= ex_addr_low2;
      dest_p1         <= ex_dest;
      pc_p1           <= ex_pc;
      alu_p1          <= ex_alu_result;
      side_p1         <= ex_side;
    end
  end

  always_ff @(posedge clk) begin
    if (rbuf_cap) rbuf <= data_sram_rdata;
  end

  assign req_block    = (out_cnt == CNT_W'(MAX_OUTSTANDING));
  assign mem_wb_valid = vld_p1 & ready_go & ~flush;
  assign wb_gr_we     = gr_we_p1;
  assign wb_dest      = dest_p1;
  assign wb_pc        = pc_p1;
  assign wb_result    = result;
  assign wb_exc       = exc_p1;
  assign wb_side      = side_p1;
  assign mem_exc      = vld_p1 & exc_p1;
  assign fwd_valid    = vld_p1 & gr_we_p1;
  assign fwd_dest     = dest_p1;
  assign fwd_data     = result;
  assign fwd_busy     = vld_p1 & res_from_mem_p1 & ~ready_go;

endmodule
